// File: rtl/note_detector.sv
// note_detector: binarises ADC samples with hysteresis, measures the CLK-cycle
// period between rising crossings and reports the matching scale note (one-hot)
// once the same note has been seen on CONFIRM consecutive periods.
module note_detector #(
    parameter logic [11:0] HI_TH      = 12'd2560,
    parameter logic [11:0] LO_TH      = 12'd1536,
    parameter int          TOL_SHIFT  = 6,
    parameter int          CONFIRM    = 4,
    parameter logic [19:0] TIMEOUT    = 20'd800000,
    // Nominal periods are quoted for a 100 MHz CLK; a slower CLK divides them down.
    parameter int          PERIOD_DIV = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        sample_valid,
    input  logic [11:0] mic_in,
    output logic [6:0]  note,
    output logic        note_valid,
    output logic [19:0] period,
    output logic        period_stb
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [2:0] CONFIRM_C = 3'(CONFIRM);

    // Nominal period of note idx (0 = DOH .. 6 = TI) in CLK cycles.
    function automatic logic [19:0] nominal_period(input int idx);
        int p;
        case (idx)
            0:       p = 382226;
            1:       p = 340524;
            2:       p = 303372;
            3:       p = 286346;
            4:       p = 255106;
            5:       p = 227274;
            default: p = 202478;
        endcase
        return 20'(p / PERIOD_DIV);
    endfunction

    state_t      state_reg, state_next;
    logic        level_reg, level_next;
    logic [19:0] cnt_reg, cnt_next;
    logic [2:0]  match_cnt_reg, match_cnt_next;
    logic [2:0]  match_inc;
    logic [6:0]  cand;
    logic [6:0]  cand_reg, cand_next;
    logic [6:0]  note_reg, note_next;
    logic [19:0] period_reg, period_next;
    logic        period_stb_reg, period_stb_next;
    logic        crossing;

    // One tolerance window per note; windows are disjoint so cand is one-hot or zero.
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_win
            localparam logic [19:0] NOM = nominal_period(gi);
            localparam logic [19:0] TOL = NOM >> TOL_SHIFT;
            assign cand[gi] = (cnt_reg >= NOM - TOL) && (cnt_reg <= NOM + TOL);
        end
    endgenerate

    // A rising crossing needs a valid sample while the binarised level is still low.
    assign crossing = sample_valid && !level_reg && (mic_in >= HI_TH);

    // Next-state logic: hysteresis, period counter, confirmation and lock tracking.
    always_comb begin
        state_next      = state_reg;
        level_next      = level_reg;
        cnt_next        = cnt_reg;
        match_cnt_next  = match_cnt_reg;
        cand_next       = cand_reg;
        note_next       = note_reg;
        period_next     = period_reg;
        period_stb_next = 1'b0;
        match_inc       = (match_cnt_reg >= CONFIRM_C) ? CONFIRM_C : match_cnt_reg + 3'd1;

        if (sample_valid) begin
            if (mic_in >= HI_TH) begin
                level_next = 1'b1;
            end else if (mic_in <= LO_TH) begin
                level_next = 1'b0;
            end
        end

        if (crossing) begin
            cnt_next = 20'd1;
        end else if (state_reg != IDLE && cnt_reg != TIMEOUT) begin
            cnt_next = cnt_reg + 20'd1;
        end

        unique case (state_reg)
            IDLE: begin
                // First crossing only arms; there is no previous edge to measure from.
                if (crossing) begin
                    state_next     = MEASURE;
                    match_cnt_next = 3'd0;
                end
            end
            MEASURE, LOCKED: begin
                if (crossing) begin
                    period_next     = cnt_reg;
                    period_stb_next = 1'b1;
                    if (cand == 7'd0) begin
                        cand_next      = 7'd0;
                        match_cnt_next = 3'd0;
                        note_next      = 7'd0;
                        state_next     = MEASURE;
                    end else if (cand == cand_reg) begin
                        match_cnt_next = match_inc;
                        if (match_inc == CONFIRM_C) begin
                            note_next  = cand;
                            state_next = LOCKED;
                        end
                    end else begin
                        cand_next      = cand;
                        match_cnt_next = 3'd1;
                        if (state_reg == LOCKED) begin
                            note_next  = 7'd0;
                            state_next = MEASURE;
                        end
                    end
                end else if (cnt_reg == TIMEOUT) begin
                    // Tone has gone away; drop back and wait for a fresh arming edge.
                    state_next     = IDLE;
                    note_next      = 7'd0;
                    match_cnt_next = 3'd0;
                    cand_next      = 7'd0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg      <= IDLE;
            level_reg      <= 1'b0;
            cnt_reg        <= 20'd0;
            match_cnt_reg  <= 3'd0;
            cand_reg       <= 7'd0;
            note_reg       <= 7'd0;
            period_reg     <= 20'd0;
            period_stb_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            level_reg      <= level_next;
            cnt_reg        <= cnt_next;
            match_cnt_reg  <= match_cnt_next;
            cand_reg       <= cand_next;
            note_reg       <= note_next;
            period_reg     <= period_next;
            period_stb_reg <= period_stb_next;
        end
    end

    assign note       = note_reg;
    assign note_valid = |note_reg;
    assign period     = period_reg;
    assign period_stb = period_stb_reg;

endmodule

// File: tb/tb_note_detector.sv
// tb_note_detector: randomised square-wave stimulus against a behavioural model
// that tracks elapsed time since the last crossing and the history of classified
// periods; a single compare process checks every cycle plus literal pin checks.
module tb_note_detector;

    localparam int PDIV = 400;
    localparam int TO   = 2000;
    localparam int HI   = 2560;
    localparam int LO   = 1536;
    localparam int CONF = 4;

    logic        clk;
    logic        rst;
    logic        sv;
    logic [11:0] mic;
    logic [6:0]  note;
    logic        note_valid;
    logic [19:0] period;
    logic        period_stb;

    note_detector #(
        .TIMEOUT    (20'(TO)),
        .PERIOD_DIV (PDIV)
    ) dut (
        .CLK          (clk),
        .RESET        (rst),
        .sample_valid (sv),
        .mic_in       (mic),
        .note         (note),
        .note_valid   (note_valid),
        .period       (period),
        .period_stb   (period_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          nom_full [7] = '{382226, 340524, 303372, 286346, 255106, 227274, 202478};
    bit          m_armed;
    bit          m_level;
    bit          m_cross;
    longint      m_cyc;
    longint      m_last;
    longint      m_el;
    int          hist [$];
    logic [6:0]  exp_note;
    logic [19:0] exp_period;
    logic        exp_stb;

    // Which note (1..7) an elapsed time falls within, 0 if none.
    function automatic int classify(input longint e);
        longint p;
        longint d;
        for (int i = 0; i < 7; i++) begin
            p = nom_full[i] / PDIV;
            d = e - p;
            if (d < 0) d = -d;
            if (d <= (p >> 6)) return i + 1;
        end
        return 0;
    endfunction

    // Note is reported when the last CONF classifications agree on a real note.
    function automatic logic [6:0] lock_of();
        int c;
        int n;
        n = hist.size();
        if (n < CONF) return 7'd0;
        c = hist[n-1];
        if (c == 0) return 7'd0;
        for (int i = 2; i <= CONF; i++) begin
            if (hist[n-i] != c) return 7'd0;
        end
        return 7'(1 << (c - 1));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_armed    = 1'b0;
            m_level    = 1'b0;
            hist.delete();
            exp_note   = 7'd0;
            exp_period = 20'd0;
            exp_stb    = 1'b0;
        end else begin
            m_cross = sv && !m_level && (int'(mic) >= HI);
            m_el    = 0;
            if (m_armed) m_el = ((m_cyc - m_last) > TO) ? TO : (m_cyc - m_last);
            exp_stb = 1'b0;
            if (m_cross) begin
                if (!m_armed) begin
                    m_armed = 1'b1;
                    hist.delete();
                end else begin
                    exp_period = 20'(m_el);
                    exp_stb    = 1'b1;
                    hist.push_back(classify(m_el));
                    if (hist.size() > 8) void'(hist.pop_front());
                    exp_note = lock_of();
                end
                m_last = m_cyc;
            end else if (m_armed && m_el == TO) begin
                m_armed  = 1'b0;
                hist.delete();
                exp_note = 7'd0;
            end
            if (sv) begin
                if (int'(mic) >= HI) m_level = 1'b1;
                else if (int'(mic) <= LO) m_level = 1'b0;
            end
            m_cyc++;
        end
    end

    // ---------------- compare process ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int stb_total = 0;
    int stb_base = 0;
    int pin_id = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        n_cmp++;
        if (note !== exp_note || note_valid !== (|exp_note) ||
            period !== exp_period || period_stb !== exp_stb) begin
            n_bad++;
            $display("FAIL cycle t=%0t: got note=%b valid=%b period=%0d stb=%b, required note=%b valid=%b period=%0d stb=%b",
                     $time, note, note_valid, period, period_stb,
                     exp_note, |exp_note, exp_period, exp_stb);
        end
        if (period_stb === 1'b1) stb_total++;
        case (pin_id)
            1: begin
                chk("reset_note", note, 0);
                chk("reset_valid", note_valid, 0);
                chk("reset_period", period, 0);
                chk("reset_stb", period_stb, 0);
            end
            2: begin
                chk("doh_note", note, 7'b0000001);
                chk("doh_period", period, 955);
            end
            3: begin
                chk("ti_note", note, 7'b1000000);
                chk("ti_period_window", (period >= 20'd496 && period <= 20'd516) ? 1 : 0, 1);
            end
            4:  chk("mi_note", note, 7'b0000100);
            5: begin
                chk("fa_note", note, 7'b0001000);
                chk("fa_period", period, 715);
            end
            6:  chk("soh_note", note, 7'b0010000);
            7: begin
                chk("timeout_note", note, 0);
                chk("timeout_period_held", period, 637);
            end
            8: begin
                chk("inband_stb_count", stb_total - stb_base, 0);
                chk("inband_note", note, 0);
            end
            9: begin
                chk("gap_stb_count", stb_total - stb_base, 5);
                chk("gap_note", note, 0);
                chk("gap_period", period, 825);
            end
            10: chk("la_note", note, 7'b0100000);
            11: begin
                chk("async_reset_note", note, 0);
                chk("async_reset_valid", note_valid, 0);
                chk("async_reset_period", period, 0);
            end
            12: chk("relock_doh_note", note, 7'b0000001);
            99: stb_base = stb_total;
            default: ;
        endcase
    end

    // ---------------- stimulus ----------------
    task automatic pin(input int id);
        @(posedge clk); #1;
        pin_id = id;
        @(posedge clk); #1;
        pin_id = 0;
    endtask

    // Square wave of per cycles, high half first; samples strobed every div cycles.
    task automatic square(input int per, input int nper, input int div);
        int  h1;
        int  ph;
        int  n;
        bit  hi;
        bit  first;
        h1 = per / 2;
        ph = int'($urandom_range(0, div - 1));
        n  = 0;
        for (int p = 0; p < nper; p++) begin
            for (int k = 0; k < per; k++) begin
                hi    = (k < h1);
                first = (k == 0) || (k == h1);
                if (hi) mic = 12'($urandom_range(2560, 4095));
                else    mic = 12'($urandom_range(0, 1536));
                if (!first && div == 1 && $urandom_range(0, 3) == 0)
                    mic = 12'($urandom_range(1537, 2559));
                sv = ((n + ph) % div) == 0;
                n++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic hold_low(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            mic = 12'($urandom_range(0, 1536));
            sv  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    task automatic inband(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            mic = (i % 2 == 1) ? 12'd2100 : 12'd2000;
            sv  = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        sv  = 1'b0;
        mic = 12'd0;
        repeat (3) @(posedge clk);
        #1;
        pin(1);
        rst = 1'b0;

        square(955, 6, 1);   pin(2);     // DOH
        square(506, 6, 10);  pin(3);     // TI, sparse sampling
        square(758, 6, 1);   pin(4);     // MI
        square(715, 7, 1);   pin(5);     // switch to FA
        square(637, 6, 1);   pin(6);     // SOH
        hold_low(TO + 20);   pin(7);     // tone stops -> timeout
        pin(99); inband(400);        pin(8);
        pin(99); square(825, 6, 1);  pin(9);   // between RE and MI
        square(568, 6, 1);   pin(10);    // LA

        // Asynchronous reset while locked, observed before the next clock edge.
        @(posedge clk); #1;
        rst    = 1'b1;
        pin_id = 11;
        @(posedge clk); #1;
        pin_id = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        square(955, 6, 1);   pin(12);    // re-arm and lock after reset

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
